offchip_mem_responder: RTL
==========================

Name: offchip_mem_responder

Overview:
- Synthesizable multi-channel external-memory slave that sits directly downstream of the HLS top's master memory port (Mout_*).
- Returns read data and per-channel DataRdy with configurable read/write latency, and ORs in the top's own slave responses (Sout_*).
- Replaces the hand-written memory model in generated benches so the same responder is reused across benchmarks.

Parameters:
- CHANNELS, 2, number of independent memory channels
- ADDR_W, 9, address bits per channel
- DATA_W, 8, data bits per channel (byte lane)
- MEMSIZE, 256, bytes in the internal array
- BASE_ADDR, 0, first address of the window served
- READ_DELAY, 2, cycles from read acceptance edge to DataRdy (>=1)
- WRITE_DELAY, 1, cycles from write acceptance edge to DataRdy (>=1)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- Mout_oe_ram  in  CHANNELS  per-channel read request
- Mout_we_ram  in  CHANNELS  per-channel write request
- Mout_addr_ram  in  CHANNELS*ADDR_W  per-channel byte address
- Mout_Wdata_ram  in  CHANNELS*DATA_W  per-channel write data
- Mout_data_ram_size  in  CHANNELS*4  per-channel access width in bits (0..8)
- Sout_Rdata_ram  in  CHANNELS*DATA_W  read data from the top's slave path
- Sout_DataRdy  in  CHANNELS  ready from the top's slave path
- init_we  in  1  preload write strobe
- init_addr  in  ADDR_W  preload address (window-relative)
- init_data  in  DATA_W  preload byte
- M_Rdata_ram  out  CHANNELS*DATA_W  read data to the top
- M_DataRdy  out  CHANNELS  ready to the top
- error  out  1  sticky protocol error

Behaviour:
- Reset: all channel FSMs go to IDLE, response registers clear, error=0. M_Rdata_ram and M_DataRdy equal the Sout_* values (internal contribution is 0). Array contents are not cleared.
- In-window test: BASE_ADDR <= addr < BASE_ADDR+MEMSIZE. Out-of-window requests get no internal response; the internal contribution stays 0.
- Per-channel FSM states: IDLE, RD_WAIT, WR_WAIT, RESP.
- IDLE: samples inputs at each edge.
  - oe=1 and we=0 in-window: the array byte is captured at this edge, a counter loads READ_DELAY-1, next state is RD_WAIT (RESP directly if READ_DELAY=1).
  - we=1 and oe=0 in-window: the masked byte is committed at this edge, the counter loads WRITE_DELAY-1, next state is WR_WAIT (or RESP).
  - oe=1 and we=1: error is set (sticky until reset), the request is ignored, state stays IDLE.
- RD_WAIT / WR_WAIT: the counter decrements each cycle; at 0 the next state is RESP.
- RESP: DataRdy is high for exactly one cycle, and for reads the captured byte drives the channel lane. Inputs are not sampled; next state is IDLE. The master must hold its request until DataRdy and drop it in the following cycle.
- Latency: DataRdy is high during cycle T+READ_DELAY (reads) or T+WRITE_DELAY (writes), where T is the acceptance edge.
- Outputs: M_Rdata_ram lane = internal byte | Sout_Rdata_ram lane; M_DataRdy = internal ready | Sout_DataRdy. The internal byte is 0 outside RESP.
- Write mask: mask = (1<<size)-1 for size<8, 0xFF for size>=8. New byte = (Wdata & mask) | (old & ~mask). Size 0 leaves the byte unchanged but still responds.
- Simultaneous events:
  - Two channels writing the same address on one edge: the higher channel index wins.
  - Read and write to the same address on one edge: the read returns the old byte.
  - init_we has lowest priority against channel writes on the same address.
- Reset mid-operation: outstanding responses are dropped, with no DataRdy pulse after the reset edge.

Optional Feature:
- Macro: OFFCHIP_MEM_RANDOM_STALL_EN.
- When defined: an 8-bit Fibonacci LFSR (taps 8,6,5,4) is seeded to 0x5A on reset and advances every cycle. At each acceptance, the channel's delay is extended by lfsr[1:0] cycles (0..3), which exercises master tolerance of variable latency.
- When undefined: the LFSR is absent and latency is exactly READ_DELAY/WRITE_DELAY.

Test Plan:
- Preload addr 0x10=0xA5; ch0 read 0x10 accepted at edge T -> M_DataRdy[0]=1 and M_Rdata_ram[7:0]=0xA5 only in cycle T+2; 0 before and after.
- ch1 write 0x20, Wdata 0xFF, size 4, old byte 0x30 -> DataRdy[1] in cycle T+1; a later read of 0x20 returns 0x3F.
- ch0 oe=1 and we=1 at addr 0x05 -> error=1 and stays 1, no DataRdy; reset -> error=0.
- Both channels write 0x40 on the same edge (ch0 0x11, ch1 0x22, size 8) -> read of 0x40 returns 0x22.
- ch0 read at addr 0x150 (out of window), Sout_DataRdy[0]=1, Sout_Rdata 0x7E -> M_DataRdy[0]=1, M_Rdata_ram[7:0]=0x7E, no internal pulse.
- Reset asserted in cycle T+1 of a pending read -> no DataRdy in cycle T+2, FSM in IDLE, next read serviced normally.

Source files
------------

// File: rtl/offchip_mem_responder_if.sv
// Bus between the HLS top's master memory port and the off-chip memory responder.
// The master side also drives the top's own slave responses (Sout_*) that get merged in.
interface offchip_mem_responder_if #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned ADDR_W   = 9,
  parameter int unsigned DATA_W   = 8
);
  logic [CHANNELS-1:0]        Mout_oe_ram;
  logic [CHANNELS-1:0]        Mout_we_ram;
  logic [CHANNELS*ADDR_W-1:0] Mout_addr_ram;
  logic [CHANNELS*DATA_W-1:0] Mout_Wdata_ram;
  logic [CHANNELS*4-1:0]      Mout_data_ram_size;
  logic [CHANNELS*DATA_W-1:0] Sout_Rdata_ram;
  logic [CHANNELS-1:0]        Sout_DataRdy;
  logic [CHANNELS*DATA_W-1:0] M_Rdata_ram;
  logic [CHANNELS-1:0]        M_DataRdy;

  modport master (
    output Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size,
    output Sout_Rdata_ram, Sout_DataRdy,
    input  M_Rdata_ram, M_DataRdy
  );

  modport slave (
    input  Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size,
    input  Sout_Rdata_ram, Sout_DataRdy,
    output M_Rdata_ram, M_DataRdy
  );
endinterface

// File: rtl/offchip_mem_responder.sv
// Multi-channel external-memory slave with fixed read/write latency and Sout_* merge.
// Define OFFCHIP_MEM_RANDOM_STALL_EN to add 0..3 LFSR-driven stall cycles per access.
module offchip_mem_responder #(
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned MEMSIZE     = 256,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned READ_DELAY  = 2,
  parameter int unsigned WRITE_DELAY = 1
) (
  input  logic                        clock,
  input  logic                        reset,
  offchip_mem_responder_if.slave      bus,
  input  logic                        init_we,
  input  logic [ADDR_W-1:0]           init_addr,
  input  logic [DATA_W-1:0]           init_data,
  output logic                        error
);

  localparam int unsigned IdxW = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;
  localparam int unsigned CntW = 8;

  typedef enum logic [1:0] {StIdle, StRdWait, StWrWait, StResp} state_e;

  state_e            state_q [CHANNELS];
  state_e            state_d [CHANNELS];
  logic [CntW-1:0]   cnt_q   [CHANNELS];
  logic [CntW-1:0]   cnt_d   [CHANNELS];
  logic [DATA_W-1:0] rdata_q [CHANNELS];
  logic [DATA_W-1:0] rdata_d [CHANNELS];
  logic              error_q, error_d;

  logic [DATA_W-1:0] mem_q [MEMSIZE];

  logic [31:0]       addr_w  [CHANNELS];
  logic [IdxW-1:0]   idx     [CHANNELS];
  logic [DATA_W-1:0] mask    [CHANNELS];
  logic [DATA_W-1:0] wr_byte [CHANNELS];
  logic [CHANNELS-1:0] in_win;
  logic [CHANNELS-1:0] wr_en;
  logic [1:0]          stall;

`ifdef OFFCHIP_MEM_RANDOM_STALL_EN
  logic [7:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, taps 8,6,5,4
  always_comb lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_ff @(posedge clock) begin
    if (reset) lfsr_q <= 8'h5A;
    else       lfsr_q <= lfsr_d;
  end

  assign stall = lfsr_q[1:0];
`else
  assign stall = 2'b00;
`endif

  // Per-channel address decode and masked write-merge against the current byte
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      addr_w[c] = 32'(bus.Mout_addr_ram[c*ADDR_W +: ADDR_W]);
      // Unsigned wrap makes addresses below BASE_ADDR fall out of window too
      in_win[c] = (addr_w[c] - BASE_ADDR) < MEMSIZE;
      idx[c]    = IdxW'(addr_w[c] - BASE_ADDR);
      mask[c]   = '0;
      for (int b = 0; b < DATA_W; b++) begin
        mask[c][b] = b < int'(bus.Mout_data_ram_size[c*4 +: 4]);
      end
      wr_byte[c] = (bus.Mout_Wdata_ram[c*DATA_W +: DATA_W] & mask[c]) |
                   (mem_q[idx[c]] & ~mask[c]);
    end
  end

  always_comb begin
    error_d = error_q;
    wr_en   = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      rdata_d[c] = rdata_q[c];
      unique case (state_q[c])
        StIdle: begin
          if (bus.Mout_oe_ram[c] && bus.Mout_we_ram[c]) begin
            error_d = 1'b1;
          end else if (bus.Mout_oe_ram[c] && in_win[c]) begin
            rdata_d[c] = mem_q[idx[c]];
            cnt_d[c]   = CntW'(READ_DELAY - 1) + CntW'(stall);
            state_d[c] = (cnt_d[c] == '0) ? StResp : StRdWait;
          end else if (bus.Mout_we_ram[c] && in_win[c]) begin
            wr_en[c]   = 1'b1;
            rdata_d[c] = '0;
            cnt_d[c]   = CntW'(WRITE_DELAY - 1) + CntW'(stall);
            state_d[c] = (cnt_d[c] == '0) ? StResp : StWrWait;
          end
        end
        StRdWait, StWrWait: begin
          cnt_d[c] = cnt_q[c] - 1'b1;
          if (cnt_q[c] <= CntW'(1)) state_d[c] = StResp;
        end
        StResp:  state_d[c] = StIdle;
        default: state_d[c] = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      error_q <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= StIdle;
        cnt_q[c]   <= '0;
        rdata_q[c] <= '0;
      end
    end else begin
      error_q <= error_d;
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
        rdata_q[c] <= rdata_d[c];
      end
    end
  end

  // Later assignments win: init < channel 0 < channel 1 ...
  always_ff @(posedge clock) begin
    if (init_we && (32'(init_addr) < MEMSIZE)) mem_q[IdxW'(init_addr)] <= init_data;
    if (!reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (wr_en[c]) mem_q[idx[c]] <= wr_byte[c];
      end
    end
  end

  always_comb begin
    bus.M_Rdata_ram = '0;
    bus.M_DataRdy   = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      bus.M_Rdata_ram[c*DATA_W +: DATA_W] =
          ((state_q[c] == StResp) ? rdata_q[c] : '0) | bus.Sout_Rdata_ram[c*DATA_W +: DATA_W];
      bus.M_DataRdy[c] = (state_q[c] == StResp) | bus.Sout_DataRdy[c];
    end
  end

  assign error = error_q;

endmodule
